// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg
//   Shared definitions for the fetch-to-decode instruction queue:
//   entry width and field offsets as functions of the address and cause
//   widths, pack/unpack helpers for the default-width entry, and the
//   thermometer run-length and popcount helpers used for push/pop counts.
package inst_queue_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_CAUSE_W = 7;
    localparam int INST_W      = 32;

    // Entry layout, MSB -> LSB: {pred_addr, pc, inst, exc, cause}.
    // The instruction word is always 32 bits wide; PC and predicted address
    // follow the address width.
    function automatic int ent_width(input int addr_w, input int cause_w);
        return 2 * addr_w + INST_W + 1 + cause_w;
    endfunction

    function automatic int exc_bit(input int cause_w);
        return cause_w;
    endfunction

    function automatic int inst_lsb(input int cause_w);
        return cause_w + 1;
    endfunction

    function automatic int pc_lsb(input int cause_w);
        return cause_w + 1 + INST_W;
    endfunction

    function automatic int pred_lsb(input int addr_w, input int cause_w);
        return cause_w + 1 + INST_W + addr_w;
    endfunction

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pred_addr;
        logic [DEF_ADDR_W-1:0]  pc;
        logic [INST_W-1:0]      inst;
        logic                   exc;
        logic [DEF_CAUSE_W-1:0] cause;
    } entry_t;

    localparam int DEF_ENT_W = $bits(entry_t);

    function automatic logic [DEF_ENT_W-1:0] pack_entry(input entry_t e);
        return e;
    endfunction

    function automatic entry_t unpack_entry(input logic [DEF_ENT_W-1:0] v);
        return entry_t'(v);
    endfunction

    // Length of the contiguous run of ones starting at bit 0, looking at
    // the low w bits only. Anything after the first zero is ignored.
    function automatic int unsigned run_len(input logic [31:0] v, input int unsigned w);
        int unsigned n;
        logic        open;
        n    = 0;
        open = 1'b1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w && open) begin
                if (v[i]) n++;
                else      open = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v, input int unsigned w);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w && v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// inst_queue
//   Fetch-to-decode instruction queue. One circular buffer of per-instruction
//   entries; fetch pushes 0..FW slots and decode pops 0..IW entries per cycle,
//   independently. Each entry carries {pred_addr, pc, inst, exc, cause}.
//
// Ports
//   clk, rst (sync, active-low), flush (drop all contents, beats push/pop)
//   in_valid[FW]      push valid per slot, slot 0 oldest, leading run accepted
//   in_pc/in_inst/in_pred_addr  per-slot payload
//   in_exc, in_cause  packet exception, tagged onto every accepted slot
//   in_ready, stall   room for a full packet (from registered count only)
//   out_valid[IW]     thermometer of held entries
//   out_data[IW]      oldest IW entries, zero where out_valid is low
//   pop[IW]           decode consume mask, leading run masked by out_valid
//   count             entries held
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int FW      = 2,
    parameter int IW      = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CAUSE_W = DEF_CAUSE_W,
    localparam int ENT_W  = ent_width(ADDR_W, CAUSE_W),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [FW-1:0]         in_valid,
    input  logic [FW*ADDR_W-1:0]  in_pc,
    input  logic [FW*INST_W-1:0]  in_inst,
    input  logic [FW*ADDR_W-1:0]  in_pred_addr,
    input  logic                  in_exc,
    input  logic [CAUSE_W-1:0]    in_cause,
    output logic                  in_ready,
    output logic                  stall,
    output logic [IW-1:0]         out_valid,
    output logic [IW*ENT_W-1:0]   out_data,
    input  logic [IW-1:0]         pop,
    output logic [CNT_W-1:0]      count
);

    localparam int EXC_BIT  = exc_bit(CAUSE_W);
    localparam int INST_LSB = inst_lsb(CAUSE_W);
    localparam int PC_LSB   = pc_lsb(CAUSE_W);
    localparam int PRED_LSB = pred_lsb(ADDR_W, CAUSE_W);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] wdata [FW];
    int unsigned      push_n;
    int unsigned      pop_m;

    // No pop credit: in_ready looks only at the registered count so there is
    // no combinational path from decode's pop back to fetch.
    assign in_ready = (count <= CNT_W'(DEPTH - FW));
    assign stall    = ~in_ready;

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < IW; i++) begin
            out_valid[i] = (count > CNT_W'(i));
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < IW; i++) begin
            if (out_valid[i]) begin
                out_data[i*ENT_W +: ENT_W] = mem[rd_ptr + PTR_W'(i)];
            end
        end
    end

    // A packet that does not fit is ignored whole; fetch re-presents it.
    always_comb begin
        push_n = in_ready ? run_len(32'(in_valid), FW) : 0;
        pop_m  = run_len(32'(pop & out_valid), IW);
    end

    always_comb begin
        for (int k = 0; k < FW; k++) begin
            wdata[k]                              = '0;
            wdata[k][CAUSE_W-1:0]                 = in_cause;
            wdata[k][EXC_BIT]                     = in_exc;
            wdata[k][INST_LSB +: INST_W]          = in_inst[k*INST_W +: INST_W];
            wdata[k][PC_LSB +: ADDR_W]            = in_pc[k*ADDR_W +: ADDR_W];
            wdata[k][PRED_LSB +: ADDR_W]          = in_pred_addr[k*ADDR_W +: ADDR_W];
        end
    end

    // Storage is never reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            for (int unsigned k = 0; k < FW; k++) begin
                if (k < push_n) begin
                    mem[wr_ptr + PTR_W'(k)] <= wdata[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            rd_ptr <= rd_ptr + PTR_W'(pop_m);
            count  <= count + CNT_W'(push_n) - CNT_W'(pop_m);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (count <= CNT_W'(DEPTH))
                else $error("inst_queue: count above DEPTH");
            assert (popcount(32'(out_valid), IW) == run_len(32'(out_valid), IW))
                else $error("inst_queue: out_valid not a thermometer");
            if (!flush) begin
                assert (run_len(32'(pop), IW) <= pop_m)
                    else $warning("inst_queue: pop beyond out_valid, extra bits masked");
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int FW    = 2;
    localparam int EW    = 104;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   in_valid = '0;
    logic [63:0]  in_pc = '0;
    logic [63:0]  in_inst = '0;
    logic [63:0]  in_pred = '0;
    logic         in_exc = 1'b0;
    logic [6:0]   in_cause = '0;
    logic         in_ready;
    logic         stall;
    logic [1:0]   out_valid;
    logic [207:0] out_data;
    logic [1:0]   pop = '0;
    logic [4:0]   count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the queue contents, oldest first.
    logic [EW-1:0] mq[$];

    inst_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_pred_addr(in_pred), .in_exc(in_exc), .in_cause(in_cause),
        .in_ready(in_ready), .stall(stall),
        .out_valid(out_valid), .out_data(out_data),
        .pop(pop), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int run2(input logic [1:0] v);
        return v[0] ? (v[1] ? 2 : 1) : 0;
    endfunction

    function automatic logic [EW-1:0] exp_slot(input int i);
        return (i < mq.size()) ? mq[i] : '0;
    endfunction

    function automatic logic [1:0] exp_valid();
        return {mq.size() > 1, mq.size() > 0};
    endfunction

    task automatic set_pkt(input logic [31:0] pc0, input logic [1:0] v,
                           input logic exc, input logic [6:0] cause);
        for (int k = 0; k < 2; k++) begin
            in_pc[k*32 +: 32]   = pc0 + 32'(4 * k);
            in_pred[k*32 +: 32] = pc0 + 32'(4 * k) + 32'd8;
            in_inst[k*32 +: 32] = $urandom;
        end
        in_valid = v;
        in_exc   = exc;
        in_cause = cause;
    endtask

    // Clock one edge and advance the model from the inputs seen at that edge.
    task automatic tick();
        int n;
        int m;
        n = (mq.size() <= DEPTH - FW) ? run2(in_valid) : 0;
        m = run2(pop);
        if (m > mq.size()) m = mq.size();
        @(posedge clk);
        if (!rst || flush) begin
            mq.delete();
        end else begin
            repeat (m) void'(mq.pop_front());
            for (int k = 0; k < n; k++)
                mq.push_back({in_pred[k*32 +: 32], in_pc[k*32 +: 32],
                              in_inst[k*32 +: 32], in_exc, in_cause});
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        pop      = '0;
        flush    = 1'b0;
        in_exc   = 1'b0;
        in_cause = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        vectors++;
        if (count !== 5'd0) begin
            miscompares++; $display("FAIL reset_count: got %0d want 0", count);
        end
        vectors++;
        if (out_valid !== 2'b00) begin
            miscompares++; $display("FAIL reset_out_valid: got %b want 00", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1 || stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: got in_ready=%b stall=%b want 1/0", in_ready, stall);
        end
        vectors++;
        if (out_data !== '0) begin
            miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
    endtask

    task automatic test_push();
        entry_t e0;
        entry_t e1;
        do_reset();
        set_pkt(32'h1C00_0000, 2'b11, 1'b0, 7'h00);
        tick();
        idle_inputs();
        e0 = unpack_entry(out_data[0 +: EW]);
        e1 = unpack_entry(out_data[EW +: EW]);
        vectors++;
        if (out_valid !== 2'b11 || count !== 5'd2) begin
            miscompares++; $display("FAIL push_state: got valid=%b count=%0d want 11/2", out_valid, count);
        end
        vectors++;
        if (e0.pc !== 32'h1C00_0000) begin
            miscompares++; $display("FAIL push_slot0_pc: got %h want 1c000000", e0.pc);
        end
        vectors++;
        if (e1.pred_addr !== 32'h1C00_000C) begin
            miscompares++; $display("FAIL push_slot1_pred: got %h want 1c00000c", e1.pred_addr);
        end
        vectors++;
        if (out_data !== {exp_slot(1), exp_slot(0)}) begin
            miscompares++; $display("FAIL push_data: got %h want %h", out_data, {exp_slot(1), exp_slot(0)});
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int p = 0; p < 9; p++) begin
            set_pkt(32'h3000_0000 + 32'(8 * p), 2'b11, 1'b0, 7'h00);
            tick();
            vectors++;
            if (count !== 5'(mq.size()) || in_ready !== (mq.size() <= 14)) begin
                miscompares++; $display("FAIL fill_model p%0d: got count=%0d rdy=%b want %0d", p, count, in_ready, mq.size());
            end
            if (p == 6) begin
                vectors++;
                if (count !== 5'd14 || in_ready !== 1'b1) begin
                    miscompares++; $display("FAIL fill_14: got count=%0d rdy=%b want 14/1", count, in_ready);
                end
            end
            if (p == 7) begin
                vectors++;
                if (count !== 5'd16 || in_ready !== 1'b0 || stall !== 1'b1) begin
                    miscompares++; $display("FAIL fill_16: got count=%0d rdy=%b stall=%b want 16/0/1", count, in_ready, stall);
                end
            end
        end
        vectors++;
        if (count !== 5'd16 || out_data !== {exp_slot(1), exp_slot(0)}) begin
            miscompares++; $display("FAIL fill_overflow: got count=%0d want 16", count);
        end
        idle_inputs();
    endtask

    task automatic test_mixed();
        entry_t e0;
        logic [31:0] a;
        a = 32'h5000_0100;
        do_reset();
        set_pkt(a, 2'b11, 1'b0, 7'h00);          tick();
        set_pkt(a + 32'd8, 2'b11, 1'b0, 7'h00);  tick();
        set_pkt(a + 32'd16, 2'b01, 1'b0, 7'h00); tick();
        set_pkt(a + 32'd20, 2'b11, 1'b0, 7'h00);
        pop = 2'b01;
        tick();
        e0 = unpack_entry(out_data[0 +: EW]);
        vectors++;
        if (count !== 5'd6 || e0.pc !== a + 32'd4) begin
            miscompares++; $display("FAIL mixed_push_pop: got count=%0d pc=%h want 6/%h", count, e0.pc, a + 32'd4);
        end
        set_pkt(a + 32'd28, 2'b10, 1'b0, 7'h00);
        pop = 2'b00;
        tick();
        vectors++;
        if (count !== 5'd6) begin
            miscompares++; $display("FAIL mixed_gap_push: got count=%0d want 6", count);
        end
        in_valid = 2'b00;
        pop = 2'b10;
        tick();
        e0 = unpack_entry(out_data[0 +: EW]);
        vectors++;
        if (count !== 5'd6 || e0.pc !== a + 32'd4) begin
            miscompares++; $display("FAIL mixed_gap_pop: got count=%0d pc=%h want 6/%h", count, e0.pc, a + 32'd4);
        end
        vectors++;
        if (out_data !== {exp_slot(1), exp_slot(0)} || out_valid !== exp_valid()) begin
            miscompares++; $display("FAIL mixed_data: got %h want %h", out_data, {exp_slot(1), exp_slot(0)});
        end
        idle_inputs();
    endtask

    task automatic test_stream();
        int pushed;
        int consumed;
        int cyc;
        logic [31:0] base;
        bit exp_exc[40];
        pushed = 0; consumed = 0; cyc = 0;
        base = 32'h4000_0000;
        do_reset();
        while (consumed < 40 && cyc < 600) begin
            logic [1:0] v;
            logic ex;
            int r;
            int n;
            int m;
            entry_t e;
            r = $urandom_range(0, 3);
            v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : 2'b11;
            if (pushed >= 40) v = 2'b00;
            else if (pushed == 39 && v == 2'b11) v = 2'b01;
            ex = (pushed == 10);
            set_pkt(base + 32'(4 * pushed), v, ex, ex ? 7'h0A : 7'h00);
            r = $urandom_range(0, 2);
            m = (r > mq.size()) ? mq.size() : r;
            pop = (m == 2) ? 2'b11 : (m == 1) ? 2'b01 : 2'b00;
            vectors++;
            if (count !== 5'(mq.size()) || in_ready !== (mq.size() <= 14) || out_valid !== exp_valid()) begin
                miscompares++; $display("FAIL stream_state c%0d: got count=%0d rdy=%b valid=%b want %0d", cyc, count, in_ready, out_valid, mq.size());
            end
            vectors++;
            if (out_data !== {exp_slot(1), exp_slot(0)}) begin
                miscompares++; $display("FAIL stream_data c%0d: got %h want %h", cyc, out_data, {exp_slot(1), exp_slot(0)});
            end
            for (int i = 0; i < m; i++) begin
                e = unpack_entry(out_data[i*EW +: EW]);
                vectors++;
                if (e.pc !== base + 32'(4 * (consumed + i)) || e.exc !== exp_exc[consumed + i] ||
                    e.cause !== (exp_exc[consumed + i] ? 7'h0A : 7'h00)) begin
                    miscompares++; $display("FAIL stream_order c%0d: got pc=%h exc=%b cause=%h want pc=%h exc=%b", cyc, e.pc, e.exc, e.cause, base + 32'(4 * (consumed + i)), exp_exc[consumed + i]);
                end
            end
            n = (mq.size() <= DEPTH - FW) ? run2(v) : 0;
            for (int k = 0; k < n; k++) exp_exc[pushed + k] = ex;
            tick();
            pushed   += n;
            consumed += m;
            cyc++;
        end
        vectors++;
        if (consumed != 40) begin
            miscompares++; $display("FAIL stream_complete: got %0d consumed want 40", consumed);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        entry_t e0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            set_pkt(32'h6000_0000 + 32'(8 * p), 2'b11, 1'b0, 7'h00);
            tick();
        end
        set_pkt(32'h6000_0020, 2'b01, 1'b0, 7'h00);
        tick();
        vectors++;
        if (count !== 5'd9) begin
            miscompares++; $display("FAIL flush_setup: got count=%0d want 9", count);
        end
        set_pkt(32'h6000_0024, 2'b11, 1'b0, 7'h00);
        pop = 2'b11;
        flush = 1'b1;
        tick();
        idle_inputs();
        vectors++;
        if (count !== 5'd0 || out_valid !== 2'b00 || in_ready !== 1'b1 || out_data !== '0) begin
            miscompares++; $display("FAIL flush_clear: got count=%0d valid=%b rdy=%b want 0/00/1", count, out_valid, in_ready);
        end
        set_pkt(32'h7000_0000, 2'b11, 1'b0, 7'h00);
        tick();
        idle_inputs();
        e0 = unpack_entry(out_data[0 +: EW]);
        vectors++;
        if (count !== 5'd2 || e0.pc !== 32'h7000_0000) begin
            miscompares++; $display("FAIL flush_refill: got count=%0d pc=%h want 2/70000000", count, e0.pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            set_pkt(32'h8000_0000 + 32'(8 * p), 2'b11, 1'b0, 7'h00);
            tick();
        end
        set_pkt(32'h8000_0018, 2'b11, 1'b0, 7'h00);
        pop = 2'b11;
        flush = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle_inputs();
        vectors++;
        if (count !== 5'd0 || out_valid !== 2'b00 || in_ready !== 1'b1 || out_data !== '0) begin
            miscompares++; $display("FAIL reset_mid: got count=%0d valid=%b rdy=%b want 0/00/1", count, out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_fill();
        test_mixed();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
